// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and response router for the shared system device bus.
// One outstanding transaction at a time, with a response timeout so a hung device cannot stall a host.
module bus_rr_arbiter #(
  parameter int unsigned NrHosts       = 3,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],
  output logic                      dev_req_o,
  output logic [AddressWidth-1:0]   dev_addr_o,
  output logic                      dev_we_o,
  output logic [DataWidth/8-1:0]    dev_be_o,
  output logic [DataWidth-1:0]      dev_wdata_o,
  input  logic                      dev_rvalid_i,
  input  logic [DataWidth-1:0]      dev_rdata_i,
  input  logic                      dev_err_i
);

  localparam int unsigned PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } state_e;

  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] owner_q;
  logic [PtrW-1:0] owner_next;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] winner;
  logic [PtrW:0]   scan;
  logic            win_vld;
  logic            timeout_hit;
  logic            rsp_fire;

  // Scan ptr, ptr+1, ... with a non-power-of-two wrap at NrHosts.
  always_comb begin
    win_vld = 1'b0;
    winner  = '0;
    scan    = '0;
    for (int k = 0; k < NrHosts; k++) begin
      scan = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (scan >= (PtrW+1)'(NrHosts)) begin
        scan = scan - (PtrW+1)'(NrHosts);
      end
      if (!win_vld && host_req_i[scan[PtrW-1:0]]) begin
        win_vld = 1'b1;
        winner  = scan[PtrW-1:0];
      end
    end
  end

  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
  assign rsp_fire    = (state_q == WAIT_RSP) && (dev_rvalid_i || timeout_hit);
  assign owner_next  = (owner_q == PtrW'(NrHosts - 1)) ? '0 : owner_q + 1'b1;

  // Grant and response are combinational; rst_ni gating keeps every output low during reset.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h]    = 1'b0;
      host_rvalid_o[h] = 1'b0;
      host_err_o[h]    = 1'b0;
      host_rdata_o[h]  = '0;
    end
    dev_req_o   = 1'b0;
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;

    if (rst_ni && (state_q == IDLE) && win_vld) begin
      host_gnt_o[winner] = 1'b1;
      dev_req_o          = 1'b1;
      dev_addr_o         = host_addr_i[winner];
      dev_we_o           = host_we_i[winner];
      dev_be_o           = host_be_i[winner];
      dev_wdata_o        = host_wdata_i[winner];
    end

    if (rst_ni && rsp_fire) begin
      host_rvalid_o[owner_q] = 1'b1;
      if (dev_rvalid_i) begin
        host_rdata_o[owner_q] = dev_rdata_i;
        host_err_o[owner_q]   = dev_err_i;
      end else begin
        host_err_o[owner_q]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= winner;
            cnt_q   <= '0;
            state_q <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_fire) begin
            ptr_q   <= owner_next;
            state_q <= IDLE;
          end else if (cnt_q != CntW'(TimeoutCycles)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed protocol scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_bus_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req    [N];
  logic            gnt    [N];
  logic [AW-1:0]   addr   [N];
  logic            we     [N];
  logic [DW/8-1:0] be     [N];
  logic [DW-1:0]   wdata  [N];
  logic            rvalid [N];
  logic [DW-1:0]   rdata  [N];
  logic            err    [N];
  logic            dreq;
  logic [AW-1:0]   daddr;
  logic            dwe;
  logic [DW/8-1:0] dbe;
  logic [DW-1:0]   dwdata;
  logic            drv;
  logic [DW-1:0]   drdata;
  logic            derr;

  bus_rr_arbiter #(
    .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
    .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid),
    .host_rdata_o(rdata), .host_err_o(err),
    .dev_req_o(dreq), .dev_addr_o(daddr), .dev_we_o(dwe), .dev_be_o(dbe),
    .dev_wdata_o(dwdata), .dev_rvalid_i(drv), .dev_rdata_i(drdata), .dev_err_i(derr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_no = 0;
  int gnt_log[$];
  int gnt_cyc[$];

  // Reference model: transaction-level view of the arbiter.
  bit m_busy  = 1'b0;
  int m_ptr   = 0;
  int m_owner = 0;
  int m_since = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int h;
      h = (m_ptr + k) % N;
      if (req[h]) return h;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    for (int h = 0; h < N; h++) begin
      req[h] = 1'b0; addr[h] = '0; we[h] = 1'b0; be[h] = '0; wdata[h] = '0;
    end
    drv = 1'b0; drdata = '0; derr = 1'b0;
  endtask

  task automatic check_cycle(input string tag);
    logic [N-1:0]    e_g, e_rv, e_er, o_g, o_rv, o_er;
    logic [DW-1:0]   e_rd [N];
    logic            e_req, e_we;
    logic [AW-1:0]   e_addr;
    logic [DW/8-1:0] e_be;
    logic [DW-1:0]   e_wd;
    int              w;
    bit              fire;
    #4;
    e_g = '0; e_rv = '0; e_er = '0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_be = '0; e_wd = '0; w = -1; fire = 1'b0;
    for (int h = 0; h < N; h++) e_rd[h] = '0;
    if (rst_n) begin
      if (!m_busy) begin
        w = pick();
        if (w >= 0) begin
          e_g[w] = 1'b1; e_req = 1'b1; e_addr = addr[w];
          e_we = we[w]; e_be = be[w]; e_wd = wdata[w];
        end
      end else begin
        fire = drv || (m_since == TO);
        if (fire) begin
          e_rv[m_owner] = 1'b1;
          e_er[m_owner] = drv ? derr : 1'b1;
          e_rd[m_owner] = drv ? drdata : '0;
        end
      end
    end
    for (int h = 0; h < N; h++) begin
      o_g[h] = gnt[h]; o_rv[h] = rvalid[h]; o_er[h] = err[h];
    end
    chk({tag, "_gnt"},    64'(o_g),    64'(e_g));
    chk({tag, "_rvalid"}, 64'(o_rv),   64'(e_rv));
    chk({tag, "_err"},    64'(o_er),   64'(e_er));
    chk({tag, "_dreq"},   64'(dreq),   64'(e_req));
    chk({tag, "_daddr"},  64'(daddr),  64'(e_addr));
    chk({tag, "_dwe"},    64'(dwe),    64'(e_we));
    chk({tag, "_dbe"},    64'(dbe),    64'(e_be));
    chk({tag, "_dwdata"}, 64'(dwdata), 64'(e_wd));
    for (int h = 0; h < N; h++) chk({tag, "_rdata"}, 64'(rdata[h]), 64'(e_rd[h]));
    for (int h = 0; h < N; h++) begin
      if (gnt[h] === 1'b1) begin
        gnt_log.push_back(h);
        gnt_cyc.push_back(cyc_no);
      end
    end
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_since = 1;
      end
    end else if (fire) begin
      m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
    end else begin
      m_since++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    check_cycle("reset");
    advance();
    check_cycle("reset");
    advance();
    rst_n = 1'b1;
  endtask

  int exp_rr [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    do_reset();
    check_cycle("idle");
    advance();

    // Single host read
    req[1] = 1'b1; addr[1] = 32'h8000_0000;
    check_cycle("single_req");
    chk("single_gnt1", 64'(gnt[1]), 64'd1);
    chk("single_addr", 64'(daddr), 64'h8000_0000);
    advance();
    idle_inputs();
    drv = 1'b1; drdata = 32'hDEAD_BEEF;
    check_cycle("single_rsp");
    chk("single_rvalid1", 64'(rvalid[1]), 64'd1);
    chk("single_rdata1", 64'(rdata[1]), 64'hDEAD_BEEF);
    chk("single_err1", 64'(err[1]), 64'd0);
    advance();
    idle_inputs();

    // Round-robin with all hosts requesting and a 1-cycle device
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      for (int h = 0; h < N; h++) begin
        req[h] = 1'b1; addr[h] = 32'h1000 * (h + 1);
      end
      drv = 1'b1; drdata = $urandom;
      check_cycle("rr");
      advance();
    end
    idle_inputs();
    chk("rr_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      chk("rr_order", 64'(gnt_log[i]), 64'(exp_rr[i]));
      if (i > 0) chk("rr_spacing", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd2);
    end

    // Host 1 alone moves the pointer to 2, then hosts 0 and 1 contend
    req[1] = 1'b1;
    check_cycle("ptr_setup");
    advance();
    idle_inputs(); drv = 1'b1;
    check_cycle("ptr_setup");
    advance();
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      req[0] = 1'b1; req[1] = 1'b1; drv = 1'b1;
      check_cycle("gap");
      advance();
    end
    idle_inputs();
    chk("gap_count", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() >= 2) begin
      chk("gap_first", 64'(gnt_log[0]), 64'd0);
      chk("gap_second", 64'(gnt_log[1]), 64'd1);
    end

    // Timeout: host 2, device silent, then a late response
    for (int i = 0; i <= 6; i++) begin
      idle_inputs();
      if (i == 0) begin req[2] = 1'b1; addr[2] = 32'h4000_0010; end
      if (i == 6) begin drv = 1'b1; drdata = 32'h1234_5678; end
      check_cycle("timeout");
      if (i == 4) begin
        chk("timeout_rvalid2", 64'(rvalid[2]), 64'd1);
        chk("timeout_err2", 64'(err[2]), 64'd1);
        chk("timeout_rdata2", 64'(rdata[2]), 64'd0);
      end
      if (i == 6) chk("late_rvalid", 64'({rvalid[2], rvalid[1], rvalid[0]}), 64'd0);
      advance();
    end
    idle_inputs();

    // Error passthrough on a write from host 0
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b0011; addr[0] = 32'h2000_0004; wdata[0] = 32'hA5A5_0F0F;
    check_cycle("errpass_req");
    chk("errpass_we", 64'(dwe), 64'd1);
    chk("errpass_be", 64'(dbe), 64'h3);
    advance();
    idle_inputs(); drv = 1'b1; derr = 1'b1;
    check_cycle("errpass_rsp");
    chk("errpass_rvalid0", 64'(rvalid[0]), 64'd1);
    chk("errpass_err0", 64'(err[0]), 64'd1);
    advance();
    idle_inputs();

    // Reset while a transaction is outstanding
    for (int h = 0; h < N; h++) req[h] = 1'b1;
    check_cycle("rstmid_req");
    advance();
    rst_n = 1'b0;
    check_cycle("rstmid_async");
    chk("rstmid_dreq", 64'(dreq), 64'd0);
    chk("rstmid_gnt", 64'({gnt[2], gnt[1], gnt[0]}), 64'd0);
    advance();
    rst_n = 1'b1;
    check_cycle("rstmid_after");
    chk("rstmid_gnt0", 64'(gnt[0]), 64'd1);
    advance();
    idle_inputs(); drv = 1'b1;
    check_cycle("rstmid_rsp");
    advance();
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < N; h++) begin
        req[h] = 1'($urandom_range(0, 1));
        addr[h] = $urandom; we[h] = 1'($urandom_range(0, 1));
        be[h] = 4'($urandom_range(0, 15)); wdata[h] = $urandom;
      end
      drv = ($urandom_range(0, 2) == 0);
      drdata = $urandom;
      derr = 1'($urandom_range(0, 1));
      check_cycle("random");
      advance();
    end
    idle_inputs();
    for (int i = 0; i < TO + 2; i++) begin
      check_cycle("drain");
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
